// File: rtl/four_way_rr_arbiter.sv
// Four-requester round-robin arbiter with registered grant outputs.
// A grant lasts until the owner pulses done, drops its request, or
// reaches MAX_HOLD cycles. Every grant is followed by one RELEASE cycle
// with gnt=0, which also arbitrates for the next owner.
module four_way_rr_arbiter #(
  parameter int MAX_HOLD = 8  // legal range 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [7:0] hold_cnt, hold_n;
  logic [1:0] idx_n;
  logic       valid_n;
  logic [3:0] gnt_n;
  logic [1:0] win;
  logic       any_req;
  logic       release_now;

  // Winner search: first requester at or after ptr, wrapping mod 4.
  always_comb begin
    logic [1:0] cand;
    logic       found;
    win   = 2'd0;
    found = 1'b0;
    cand  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

  // Any one of the causes ends the grant; several together still give one release.
  assign release_now = done | ~req[gnt_idx] | (hold_cnt == 8'(MAX_HOLD));

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    idx_n   = gnt_idx;
    valid_n = gnt_valid;
    case (state)
      IDLE, RELEASE: begin
        if (any_req) begin
          state_n = GRANT;
          idx_n   = win;
          valid_n = 1'b1;
          ptr_n   = win + 2'd1;  // winner drops to lowest priority
          hold_n  = 8'd1;
        end else begin
          state_n = IDLE;
          valid_n = 1'b0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_n = RELEASE;
          valid_n = 1'b0;
        end else begin
          // Cannot wrap: release fires at MAX_HOLD <= 255.
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  // 2-to-4 decode of the next index, gated by the next valid bit.
  always_comb begin
    gnt_n    = 4'b0000;
    gnt_n[0] = valid_n & ~idx_n[1] & ~idx_n[0];
    gnt_n[1] = valid_n & ~idx_n[1] &  idx_n[0];
    gnt_n[2] = valid_n &  idx_n[1] & ~idx_n[0];
    gnt_n[3] = valid_n &  idx_n[1] &  idx_n[0];
  end

  // State and output registers; outputs never see req/done combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= 8'd0;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      gnt       <= 4'b0000;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
      gnt       <= gnt_n;
    end
  end

endmodule

// File: tb/tb_four_way_rr_arbiter.sv
// Directed bench: a vector table drives the MAX_HOLD=8 instance, and
// hand-written sequences drive a MAX_HOLD=2 instance for rotation and
// coincident release causes.
module tb_four_way_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset, done, reset2, done2;
  logic [3:0] req, req2;
  logic [3:0] gnt, gnt2;
  logic [1:0] gnt_idx, gnt_idx2;
  logic       gnt_valid, gnt_valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  four_way_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  four_way_rr_arbiter #(.MAX_HOLD(2)) dut2 (
    .clk(clk), .reset(reset2), .req(req2), .done(done2),
    .gnt(gnt2), .gnt_idx(gnt_idx2), .gnt_valid(gnt_valid2)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic d,
                     input logic [3:0] g, input logic [1:0] i, input logic v);
    vec_t t;
    t.rst = r; t.req = rq; t.done = d; t.gnt = g; t.idx = i; t.vld = v;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt/idx/vld=%b want %b", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] rot[13];
    reset = 1'b1; req = 4'b1111; done = 1'b0;
    reset2 = 1'b1; req2 = 4'b0000; done2 = 1'b0;

    //     rst  req      done gnt      idx  vld
    add(1, 4'b1111, 0, 4'b0000, 2'd0, 0);  // reset held with requests
    add(1, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 0, 4'b0001, 2'd0, 1);  // first grant, ptr->1
    add(0, 4'b0100, 0, 4'b0000, 2'd0, 0);  // owner 0 drops req
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 1);  // single requester 2
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 1);
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 1);  // 3rd grant cycle
    add(0, 4'b0100, 1, 4'b0000, 2'd2, 0);  // done -> release, idx kept
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 1);  // re-grant same requester
    add(0, 4'b0000, 0, 4'b0000, 2'd2, 0);
    add(0, 4'b0000, 0, 4'b0000, 2'd2, 0);  // idle
    add(0, 4'b0000, 1, 4'b0000, 2'd2, 0);  // done with no grant ignored
    add(0, 4'b0001, 0, 4'b0001, 2'd0, 1);  // grant 0, ptr->1
    add(0, 4'b0000, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b1001, 0, 4'b1000, 2'd3, 1);  // skip 1,2 -> 3
    add(0, 4'b0001, 0, 4'b0000, 2'd3, 0);
    add(0, 4'b0001, 0, 4'b0001, 2'd0, 1);  // then 0
    for (int k = 0; k < 7; k++)
      add(0, 4'b0001, 0, 4'b0001, 2'd0, 1);  // hold cycles 2..8
    add(0, 4'b0001, 0, 4'b0000, 2'd0, 0);  // timeout at 8
    add(0, 4'b0001, 0, 4'b0001, 2'd0, 1);  // same owner after one gap
    add(0, 4'b0010, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b0010, 0, 4'b0010, 2'd1, 1);  // gnt=0010
    add(1, 4'b0011, 0, 4'b0000, 2'd0, 0);  // reset mid-grant, no RELEASE
    add(0, 4'b0011, 0, 4'b0001, 2'd0, 1);  // ptr restarted at 0
    add(0, 4'b0010, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b0011, 0, 4'b0010, 2'd1, 1);  // ptr now 1

    foreach (vq[n]) begin
      reset = vq[n].rst; req = vq[n].req; done = vq[n].done;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", n), {gnt, gnt_idx, gnt_valid},
          {vq[n].gnt, vq[n].idx, vq[n].vld});
    end

    // Rotation with MAX_HOLD=2, all requesting.
    rot = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
            4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    @(posedge clk); #1;
    reset2 = 1'b0; req2 = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rot%0d", k), {gnt2, 3'b000}, {rot[k], 3'b000});
    end
    // Owner 0 is in its first hold cycle; one more gives hold_cnt==2.
    @(posedge clk); #1;
    chk("hold2", {gnt2, gnt_idx2, gnt_valid2}, {4'b0001, 2'd0, 1'b1});
    // done, req drop and timeout together -> one release
    done2 = 1'b1; req2 = 4'b1110;
    @(posedge clk); #1;
    chk("multi_rel", {gnt2, gnt_idx2, gnt_valid2}, {4'b0000, 2'd0, 1'b0});
    done2 = 1'b0;
    @(posedge clk); #1;
    chk("after_rel", {gnt2, gnt_idx2, gnt_valid2}, {4'b0010, 2'd1, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
